dmem_responder: RTL and testbench
=================================

# dmem_responder

Multi-cycle data-memory responder for the pipelined ARM core: the memory end of the core's data-memory interface, in place of the single-cycle data memory. It accepts one word read or write per request, services it after a parameterised latency, and drives a stall signal so the memory stage holds while the access is outstanding. It lets the pipeline's hazard and stall logic be exercised against realistic slow memory.

## Interface
- DEPTH, 64: number of 32-bit words; power of two, 4..4096; AW = log2(DEPTH).
- LATENCY, 2: cycles from request acceptance to ack; 1..15.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; clears all control state.
- req  input  1  request valid; sampled only in IDLE.
- we  input  1  1 = write, 0 = read; qualified by req.
- a  input  32  byte address; word index = a[AW+1:2].
- wd  input  32  write data; qualified by req and we.
- rd  output  32  read data register; valid from the ack cycle of a read.
- ack  output  1  one-cycle completion pulse.
- busy  output  1  stall to the pipeline; combinational.
- err  output  1  access error, coincident with ack; see Configuration.

## Operation
- States: IDLE, WAIT, RESP. Counter cnt is 4 bits.
- IDLE: req=1 at a rising edge latches we, a and wd.
  - LATENCY=1: go to RESP.
  - Otherwise: go to WAIT with cnt=LATENCY-2.
- WAIT: if cnt=0, perform the access at this edge and go to RESP; otherwise decrement cnt.
- LATENCY=1: the access is performed at the acceptance edge.
- Write access: mem[idx] <= latched wd; rd unchanged.
- Read access: rd <= mem[idx].
- RESP: ack=1 for exactly one cycle, then unconditionally IDLE. req in RESP is ignored and not accepted; the requester holds req and it is accepted in the following IDLE cycle.
- busy = (IDLE and req) or WAIT. busy is 0 in RESP, so the pipeline advances on the ack cycle.
- Inputs change freely after acceptance; only the latched copies are used.
- Memory array is not reset; its contents are undefined until written.
- Reset asserted mid-operation: immediately enter IDLE with ack=0, cnt=0 and busy driven by req only. A pending write that has not yet reached its access edge is dropped.

## Timing
- Reset values: rd=0, ack=0, err=0. busy=req, since it is combinational from IDLE.
- Request accepted at edge E0; ack is high in the cycle after edge E0+(LATENCY-1), i.e. LATENCY cycles after acceptance.
- Throughput: one request per LATENCY+1 cycles when req is held continuously.
- rd holds its value until the next completed read or reset.

## Configuration
- DMEM_RSP_ERR_EN defined:
  - An access is erroneous if a[1:0]!=0 or a[31:AW+2]!=0.
  - Erroneous writes do not modify memory.
  - Erroneous reads load rd=0.
  - err=1 during the ack cycle only, 0 otherwise.
- Not defined:
  - err tied to 0.
  - a[1:0] is ignored.
  - Upper address bits are ignored, so the index wraps modulo DEPTH.
- Handshake timing is identical in both builds.

## Test plan
- Reset, then LATENCY=2: write 0xDEADBEEF to 0x10, then read 0x10.
  - Write: ack in the second cycle after acceptance.
  - Read: ack with rd=0xDEADBEEF.
  - busy is high from the req cycle through WAIT and low in RESP.
- LATENCY=1, req held high for 4 requests: ack on every other cycle; never two acks in consecutive cycles.
- Write 0x11111111 to 0x0, then read 0x100 with DEPTH=64.
  - Without macro: rd=0x11111111 (wrap).
  - With DMEM_RSP_ERR_EN: err=1, rd=0.
- Read of 0x6 with DMEM_RSP_ERR_EN: err=1 in the ack cycle, rd=0. Without the macro: rd = word 1 contents, err=0.
- Assert reset in WAIT during a write of 0xCAFEF00D to 0x20 (location previously 0x12345678).
  - ack never pulses.
  - A subsequent read of 0x20 returns 0x12345678.
- LATENCY=15: a read completes exactly 15 cycles after acceptance; busy is high for all 15 cycles from the req cycle through the last WAIT cycle.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder
// ---------------------------------------------------------------------------
// Multi-cycle data-memory responder for the pipelined ARM core. Sits at the
// memory end of the core's data-memory interface. Accepts one 32-bit word
// read or write per request, completes it LATENCY cycles after acceptance,
// and raises busy so the memory stage holds while the access is outstanding.
//
// Parameters:
//   DEPTH    number of 32-bit words (power of two, 4..4096)
//   LATENCY  cycles from acceptance to ack (1..15)
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high; clears all control state
//   req    request valid, sampled only while idle
//   we     1 = write, 0 = read (qualified by req)
//   a      byte address; word index = a[AW+1:2]
//   wd     write data (qualified by req and we)
//   rd     read-data register; valid from the ack cycle of a read
//   ack    one-cycle completion pulse
//   busy   combinational stall to the pipeline
//   err    access error, coincident with ack
//
// Build option:
//   DMEM_RSP_ERR_EN  when defined, misaligned or out-of-range addresses are
//                    flagged on err; such writes are dropped and such reads
//                    return 0. When undefined, err is 0, a[1:0] is ignored
//                    and the word index wraps modulo DEPTH.
// ---------------------------------------------------------------------------
module dmem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        ack,
  output logic        busy,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);

  // Initial WAIT count: WAIT lasts LATENCY-1 cycles, the access happens on
  // the edge that leaves WAIT with cnt=0.
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t          state;
  logic [3:0]      cnt;

  // Request copies captured at acceptance; inputs may change afterwards.
  logic            we_q;
  logic [AW-1:0]   idx_q;
  logic [31:0]     wd_q;
  logic            bad_q;

  logic [31:0]     mem [DEPTH];

  // Decode of the live address.
  logic [AW-1:0]   in_idx;
  logic            in_bad;

  assign in_idx = a[AW+1:2];

`ifdef DMEM_RSP_ERR_EN
  assign in_bad = (a[1:0] != 2'b00) || (a[31:AW+2] != '0);
`else
  assign in_bad = 1'b0;
  // Byte-offset and upper address bits are deliberately ignored here.
  logic unused_addr;
  assign unused_addr = ^{a[31:AW+2], a[1:0]};
`endif

  // Operands of the access performed at the coming edge. With LATENCY=1 the
  // access happens on the acceptance edge itself, so it uses the live inputs;
  // otherwise it uses the copies latched at acceptance.
  logic            acc_en;
  logic            acc_we;
  logic            acc_bad;
  logic [AW-1:0]   acc_idx;
  logic [31:0]     acc_wd;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    acc_en  = 1'b0;
    acc_we  = 1'b0;
    acc_bad = 1'b0;
    acc_idx = '0;
    acc_wd  = '0;
    if (LATENCY == 1) begin
      acc_en  = (state == IDLE) && req;
      acc_we  = we;
      acc_bad = in_bad;
      acc_idx = in_idx;
      acc_wd  = wd;
    end else begin
      acc_en  = (state == WAIT) && (cnt == 4'd0);
      acc_we  = we_q;
      acc_bad = bad_q;
      acc_idx = idx_q;
      acc_wd  = wd_q;
    end
  end

  // Stall while a request is being presented in IDLE or is in flight.
  // Low in RESP so the pipeline advances on the ack cycle.
  assign busy = ((state == IDLE) && req) || (state == WAIT);

  // NOTE: the storage array carries no reset; its contents are undefined
  // until written, which keeps it mappable onto RAM. The write is gated by
  // reset so an access edge that coincides with reset is dropped.
  always_ff @(posedge clk) begin
    if (acc_en && acc_we && !acc_bad && !reset) begin
      mem[acc_idx] <= acc_wd;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      we_q  <= 1'b0;
      idx_q <= '0;
      wd_q  <= '0;
      bad_q <= 1'b0;
      rd    <= '0;
      ack   <= 1'b0;
      err   <= 1'b0;
    end else begin
      ack <= 1'b0;
      err <= 1'b0;

      // The access edge is also the edge that enters RESP, so ack and err
      // are registered here and last exactly the RESP cycle.
      if (acc_en) begin
        ack <= 1'b1;
        err <= acc_bad;
        if (!acc_we) begin
          rd <= acc_bad ? 32'd0 : mem[acc_idx];
        end
      end

      case (state)
        IDLE: begin
          if (req) begin
            we_q  <= we;
            idx_q <= in_idx;
            wd_q  <= wd;
            bad_q <= in_bad;
            if (LATENCY == 1) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          // req is ignored here; a held request is taken in the next IDLE.
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
// ---------------------------------------------------------------------------
// Self-checking bench for dmem_responder. Three instances (LATENCY 1, 2, 15)
// share the clock; only one is driven at a time. The driver computes each
// expected response from a word-array reference model and pushes it on a
// scoreboard queue; a monitor pops and compares whenever an ack appears.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst;
  logic [2:0]  req;
  logic [2:0]  we;
  logic [2:0]  ack;
  logic [2:0]  busy;
  logic [2:0]  err;
  logic [31:0] a  [3];
  logic [31:0] wd [3];
  logic [31:0] rd [3];

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_lat1 (
    .clk(clk), .reset(rst[0]), .req(req[0]), .we(we[0]), .a(a[0]), .wd(wd[0]),
    .rd(rd[0]), .ack(ack[0]), .busy(busy[0]), .err(err[0])
  );

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_lat2 (
    .clk(clk), .reset(rst[1]), .req(req[1]), .we(we[1]), .a(a[1]), .wd(wd[1]),
    .rd(rd[1]), .ack(ack[1]), .busy(busy[1]), .err(err[1])
  );

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(15)) u_lat15 (
    .clk(clk), .reset(rst[2]), .req(req[2]), .we(we[2]), .a(a[2]), .wd(wd[2]),
    .rd(rd[2]), .ack(ack[2]), .busy(busy[2]), .err(err[2])
  );

  typedef struct {
    int          dut;
    bit          is_wr;
    logic [31:0] rd;
    bit          err;
    int          ack_cyc;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] mdl_mem [3][DEPTH];
  logic [31:0] mdl_rd  [3];

  int cyc   = 0;
  int tests = 0;
  int fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat(input int d);
    case (d)
      0:       return 1;
      1:       return 2;
      default: return 15;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Present one request in an idle cycle, record its expected outcome, then
  // follow busy until the expected ack cycle. Returns in the ack cycle.
  task automatic issue(input int d, input bit w, input logic [31:0] addr,
                       input logic [31:0] data, input bit hold);
    exp_t e;
    bit   bad;
    int   idx;
    @(negedge clk);
    req[d] = 1'b1;
    we[d]  = w;
    a[d]   = addr;
    wd[d]  = data;

`ifdef DMEM_RSP_ERR_EN
    bad = (addr % 4 != 0) || (addr >= DEPTH * 4);
`else
    bad = 1'b0;
`endif
    idx = int'((addr / 4) % DEPTH);
    if (w) begin
      if (!bad) mdl_mem[d][idx] = data;
    end else begin
      mdl_rd[d] = bad ? 32'd0 : mdl_mem[d][idx];
    end
    e.dut     = d;
    e.is_wr   = w;
    e.rd      = mdl_rd[d];
    e.err     = bad;
    e.ack_cyc = cyc + lat(d);
    sb.push_back(e);

    #1 check("busy_req", 32'(busy[d]), 32'd1);
    @(negedge clk);
    if (!hold) begin
      req[d] = 1'b0;
      we[d]  = 1'($urandom_range(0, 1));
      a[d]   = $urandom;
      wd[d]  = $urandom;
    end
    while (cyc < e.ack_cyc) begin
      #1 check("busy_wait", 32'(busy[d]), 32'd1);
      @(negedge clk);
    end
    #1 check("busy_resp", 32'(busy[d]), 32'd0);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (ack[i] === 1'b1) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_ack: dut %0d acked at cycle %0d, none outstanding", i, cyc);
        end else begin
          e = sb.pop_front();
          check("ack_dut", 32'(i), 32'(e.dut));
          check("ack_cycle", 32'(cyc), 32'(e.ack_cyc));
          check(e.is_wr ? "rd_after_write" : "rd_read", rd[i], e.rd);
          check("err_ack", 32'(err[i]), 32'(e.err));
        end
      end else begin
        check("err_idle", 32'(err[i]), 32'd0);
      end
    end
  end

  initial begin
    bit          w;
    int          r;
    logic [31:0] addr;

    rst = 3'b111;
    req = 3'b000;
    we  = 3'b000;
    for (int i = 0; i < 3; i++) begin
      a[i]      = '0;
      wd[i]     = '0;
      mdl_rd[i] = '0;
    end

    // Reset state; busy follows req while reset holds the FSM idle.
    repeat (2) @(negedge clk);
    req = 3'b101;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("reset_rd", rd[i], 32'd0);
      check("reset_ack", 32'(ack[i]), 32'd0);
      check("reset_err", 32'(err[i]), 32'd0);
      check("reset_busy", 32'(busy[i]), 32'(req[i]));
    end
    @(negedge clk);
    rst = 3'b000;
    req = 3'b000;
    #1;
    for (int i = 0; i < 3; i++) check("idle_busy_low", 32'(busy[i]), 32'd0);
    req[1] = 1'b1;
    #1 check("idle_busy_high", 32'(busy[1]), 32'd1);
    req[1] = 1'b0;

    // Fill every word of every instance so all later reads are defined.
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < DEPTH; i++)
        issue(d, 1'b1, 32'(i * 4), $urandom, 1'b0);

    // LATENCY=2: write then read back.
    issue(1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    issue(1, 1'b0, 32'h10, 32'h0, 1'b0);

    // LATENCY=1 with req held: one ack every other cycle.
    for (int k = 0; k < 4; k++)
      issue(0, k < 2, 32'h40 + 32'(4 * (k % 2)), $urandom, 1'b1);
    req[0] = 1'b0;

    // Wrap (or error) on an out-of-range address, and a misaligned read.
    issue(1, 1'b1, 32'h0, 32'h11111111, 1'b0);
    issue(1, 1'b0, 32'h100, 32'h0, 1'b0);
    issue(1, 1'b0, 32'h6, 32'h0, 1'b0);

    // Reset while a write waits: no ack, location keeps its old value.
    issue(1, 1'b1, 32'h20, 32'h12345678, 1'b0);
    @(negedge clk);
    req[1] = 1'b1;
    we[1]  = 1'b1;
    a[1]   = 32'h20;
    wd[1]  = 32'hCAFEF00D;
    @(negedge clk);
    req[1] = 1'b0;
    #1 check("abort_wait_busy", 32'(busy[1]), 32'd1);
    rst[1] = 1'b1;
    req[1] = 1'b1;
    #1;
    check("abort_ack", 32'(ack[1]), 32'd0);
    check("abort_busy_req", 32'(busy[1]), 32'd1);
    check("abort_rd", rd[1], 32'd0);
    mdl_rd[1] = 32'd0;
    @(negedge clk);
    check("abort_no_ack", 32'(ack[1]), 32'd0);
    rst[1] = 1'b0;
    req[1] = 1'b0;
    #1 check("abort_idle_busy", 32'(busy[1]), 32'd0);
    issue(1, 1'b0, 32'h20, 32'h0, 1'b0);

    // LATENCY=15 read.
    issue(2, 1'b0, 32'h14, 32'h0, 1'b0);

    // Randomized traffic on every instance.
    for (int d = 0; d < 3; d++) begin
      for (int n = 0; n < 20; n++) begin
        w = 1'($urandom_range(0, 1));
        r = $urandom_range(0, 9);
        if (r < 6)      addr = 32'($urandom_range(0, DEPTH - 1) * 4);
        else if (r < 8) addr = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
        else            addr = $urandom;
        issue(d, w, addr, $urandom, $urandom_range(0, 3) == 0);
      end
      req[d] = 1'b0;
    end

    repeat (20) @(negedge clk);
    check("scoreboard_drain", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
